dff_reg_arbiter: RTL and testbench



---
 rtl/dff_reg_arbiter.sv | 132 +++++++++++++
 tb/tb_dff_reg_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter granting N producers one write each into a shared W-bit q/qbar register,
// with a programmable guard interval after every write.
module dff_reg_arbiter #(
    parameter int N           = 4,
    parameter int W           = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       wdata,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] owner,
    output logic [W-1:0]         q,
    output logic [W-1:0]         qbar,
    output logic                 valid,
    output logic [7:0]           wr_count
);

    // state   | meaning
    // S_IDLE  | waiting for any req; picks round-robin winner
    // S_GRANT | one-cycle grant; write committed at its closing edge
    // S_HOLD  | guard interval, req ignored, counter runs down to 1
    localparam int OW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] ptr_q, ptr_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [W-1:0]  q_q, q_d;
    logic          valid_q, valid_d;
    logic [7:0]    wr_count_q, wr_count_d;

    logic          found_hi, found_lo;
    logic [OW-1:0] win_hi, win_lo, winner;

    // Two-pass search: first requester at or above ptr, else the lowest one overall.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && !found_hi && (OW'(i) >= ptr_q)) begin
                found_hi = 1'b1;
                win_hi   = OW'(i);
            end
            if (req[i] && !found_lo) begin
                found_lo = 1'b1;
                win_lo   = OW'(i);
            end
        end
        winner = found_hi ? win_hi : win_lo;
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = '0;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        q_d        = q_q;
        valid_d    = valid_q;
        wr_count_d = wr_count_q;
        case (state_q)
            S_IDLE: begin
                if (req != '0) begin
                    state_d         = S_GRANT;
                    grant_d[winner] = 1'b1;
                    owner_d         = winner;
                end
            end
            S_GRANT: begin
                q_d        = wdata[owner_q*W +: W];
                valid_d    = 1'b1;
                wr_count_d = wr_count_q + 8'd1;
                ptr_d      = (owner_q == OW'(N-1)) ? '0 : owner_q + 1'b1;
                if (HOLD_CYCLES > 0) begin
                    state_d = S_HOLD;
                    cnt_d   = 4'(HOLD_CYCLES);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            q_q        <= '0;
            valid_q    <= 1'b0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            q_q        <= q_d;
            valid_q    <= valid_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign grant    = grant_q;
    assign owner    = owner_q;
    assign q        = q_q;
    assign qbar     = ~q_q;
    assign valid    = valid_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Scoreboarded bench for dff_reg_arbiter (N=4, W=8, HOLD_CYCLES=2).
module tb_dff_reg_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int HC = 2;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req   = '0;
    logic [N*W-1:0] wdata = '0;
    logic [N-1:0]  grant;
    logic [1:0]    owner;
    logic [W-1:0]  q, qbar;
    logic          valid;
    logic [7:0]    wr_count;

    dff_reg_arbiter #(.N(N), .W(W), .HOLD_CYCLES(HC)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .wdata    (wdata),
        .grant    (grant),
        .owner    (owner),
        .q        (q),
        .qbar     (qbar),
        .valid    (valid),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Scoreboard entry: [9:8] expected winner index, [7:0] its data word.
    logic [15:0] exp_q[$];

    logic       mon_en   = 1'b0;
    logic       rst_seen = 1'b0;
    logic       pend     = 1'b0;
    logic [7:0] pend_d   = '0;
    logic [7:0] m_q      = '0;
    logic [7:0] m_cnt    = '0;
    logic       m_valid  = 1'b0;

    always @(posedge clk) rst_seen <= reset;

    // Register model and grant scoreboard, evaluated mid-cycle.
    always @(negedge clk) begin
        logic [15:0] e;
        logic [3:0]  eg;
        if (mon_en) begin
            if (rst_seen) begin
                m_q = '0; m_cnt = '0; m_valid = 1'b0; pend = 1'b0;
            end else if (pend) begin
                m_q = pend_d; m_cnt = m_cnt + 8'd1; m_valid = 1'b1; pend = 1'b0;
            end
            total_cnt++;
            if (q !== m_q || qbar !== ~m_q || valid !== m_valid || wr_count !== m_cnt)
                $display("FAIL reg_state t=%0t q=%h/%h qbar=%h/%h valid=%b/%b wr_count=%0d/%0d",
                         $time, q, m_q, qbar, ~m_q, valid, m_valid, wr_count, m_cnt);
            else pass_cnt++;
            if (grant !== '0) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_grant t=%0t grant=%b required none", $time, grant);
                end else begin
                    e  = exp_q.pop_front();
                    eg = 4'b0001 << e[9:8];
                    if (grant !== eg || owner !== e[9:8])
                        $display("FAIL grant_order t=%0t grant=%b/%b owner=%0d/%0d",
                                 $time, grant, eg, owner, e[9:8]);
                    else pass_cnt++;
                    pend   = 1'b1;
                    pend_d = e[7:0];
                end
            end
        end
    end

    task automatic wait_grant(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (grant !== '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        reset = 1'b1;
        req   = '0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        bit bad;
        reset = 1'b1;
        req   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mon_en = 1'b1;
        total_cnt++;
        if (grant !== 4'b0000 || owner !== 2'd0)
            $display("FAIL reset_grant grant=%b owner=%0d required 0000/0", grant, owner);
        else pass_cnt++;
        total_cnt++;
        if (q !== 8'h00 || qbar !== 8'hFF)
            $display("FAIL reset_q q=%h qbar=%h required 00/ff", q, qbar);
        else pass_cnt++;
        total_cnt++;
        if (valid !== 1'b0 || wr_count !== 8'd0)
            $display("FAIL reset_valid valid=%b wr_count=%0d required 0/0", valid, wr_count);
        else pass_cnt++;
        #1 reset = 1'b0;
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (grant !== '0 || q !== 8'h00 || valid !== 1'b0 || wr_count !== 8'd0) bad = 1'b1;
        end
        total_cnt++;
        if (bad) $display("FAIL reset_quiet grant=%b q=%h required 0000/00", grant, q);
        else pass_cnt++;
    endtask

    task automatic test_single();
        @(negedge clk); #1;
        wdata[15:8] = 8'hA5;
        req = 4'b0010;
        exp_q.push_back({6'd0, 2'd1, 8'hA5});
        @(negedge clk);
        total_cnt++;
        if (grant !== 4'b0010) $display("FAIL single_latency grant=%b required 0010", grant);
        else pass_cnt++;
        #1 req = '0;
        @(negedge clk);
        total_cnt++;
        if (grant !== 4'b0000 || q !== 8'hA5 || qbar !== 8'h5A || owner !== 2'd1 ||
            valid !== 1'b1 || wr_count !== 8'd1)
            $display("FAIL single_write grant=%b q=%h qbar=%h owner=%0d valid=%b wr=%0d required 0000/a5/5a/1/1/1",
                     grant, q, qbar, owner, valid, wr_count);
        else pass_cnt++;
        settle();
    endtask

    task automatic test_contention();
        bit ok, bad;
        logic [3:0] eg;
        do_reset();
        wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        req   = 4'b1111;
        for (int i = 0; i < 5; i++) exp_q.push_back({6'd0, 2'(i % 4), 8'h11 * 8'(i % 4 + 1)});
        wait_grant(10, ok);
        total_cnt++;
        if (!ok || grant !== 4'b0001) $display("FAIL contention_first grant=%b required 0001", grant);
        else pass_cnt++;
        for (int g = 1; g <= 4; g++) begin
            bad = 1'b0;
            repeat (3) begin
                @(negedge clk);
                if (grant !== '0) bad = 1'b1;
            end
            @(negedge clk);
            eg = 4'b0001 << (g % 4);
            total_cnt++;
            if (bad || grant !== eg)
                $display("FAIL contention_spacing g=%0d grant=%b required %b after 4 cycles", g, grant, eg);
            else pass_cnt++;
        end
        #1 req = '0;
        settle();
    endtask

    task automatic test_rotation();
        bit ok;
        req = 4'b0010;
        exp_q.push_back({6'd0, 2'd1, 8'h22});
        wait_grant(10, ok);
        total_cnt++;
        if (!ok) $display("FAIL rotation_setup timeout grant=%b required 0010", grant);
        else pass_cnt++;
        #1 req = '0;
        settle();
        #1 req = 4'b0011;
        exp_q.push_back({6'd0, 2'd0, 8'h11});
        exp_q.push_back({6'd0, 2'd1, 8'h22});
        wait_grant(10, ok);
        total_cnt++;
        if (!ok || grant !== 4'b0001) $display("FAIL rotation_wrap grant=%b required 0001", grant);
        else pass_cnt++;
        wait_grant(10, ok);
        total_cnt++;
        if (!ok || grant !== 4'b0010) $display("FAIL rotation_next grant=%b required 0010", grant);
        else pass_cnt++;
        #1 req = '0;
        settle();
    endtask

    task automatic test_guard();
        bit ok, bad;
        #1 req = 4'b0001;
        exp_q.push_back({6'd0, 2'd0, 8'h11});
        wait_grant(10, ok);
        #1 req = '0;
        @(negedge clk); #1;
        req = 4'b0100;
        exp_q.push_back({6'd0, 2'd2, 8'h33});
        bad = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (grant !== '0) bad = 1'b1;
        end
        @(negedge clk);
        total_cnt++;
        if (!ok || bad || grant !== 4'b0100)
            $display("FAIL guard_interval grant=%b required 0100 four cycles after previous grant", grant);
        else pass_cnt++;
        #1 req = '0;
        @(negedge clk);
        total_cnt++;
        if (q !== 8'h33 || grant !== '0)
            $display("FAIL guard_withdraw q=%h grant=%b required 33/0000", q, grant);
        else pass_cnt++;
        settle();
    endtask

    task automatic test_reset_mid();
        bit ok;
        wdata[23:16] = 8'h7E;
        #1 req = 4'b0100;
        exp_q.push_back({6'd0, 2'd2, 8'h7E});
        wait_grant(10, ok);
        #1 reset = 1'b1;
        req = '0;
        @(negedge clk);
        total_cnt++;
        if (!ok || q !== 8'h00 || wr_count !== 8'd0 || grant !== '0 || valid !== 1'b0)
            $display("FAIL reset_mid_grant q=%h wr=%0d grant=%b valid=%b required 00/0/0000/0",
                     q, wr_count, grant, valid);
        else pass_cnt++;
        #1 reset = 1'b0;
        wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        req   = 4'b1111;
        exp_q.push_back({6'd0, 2'd0, 8'h11});
        wait_grant(10, ok);
        total_cnt++;
        if (!ok || grant !== 4'b0001) $display("FAIL reset_mid_restart grant=%b required 0001", grant);
        else pass_cnt++;
        #1 req = '0;
        settle();
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        wdata[7:0] = 8'h5C;
        req = 4'b0001;
        ok  = 1'b1;
        for (int i = 0; i < 256 && ok; i++) begin
            exp_q.push_back({6'd0, 2'd0, 8'h5C});
            wait_grant(8, ok);
            if (i == 255) #1 req = '0;
        end
        total_cnt++;
        if (!ok) $display("FAIL wrap_timeout grant=%b required periodic 0001", grant);
        else pass_cnt++;
        #1 req = '0;
        @(negedge clk);
        total_cnt++;
        if (wr_count !== 8'd0 || q !== 8'h5C || valid !== 1'b1)
            $display("FAIL wrap_count wr=%0d q=%h valid=%b required 0/5c/1", wr_count, q, valid);
        else pass_cnt++;
        settle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_rotation();
        test_guard();
        test_reset_mid();
        test_wrap();
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain left=%0d required 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
